// File: rtl/spinn_pkt_arbiter.sv
// rtl/spinn_pkt_arbiter.sv - packet arbiter sharing one spinn_driver input between NUM_REQ sources
// Round-robin or fixed-priority grant per packet into a single output register, with per-source counters.
module spinn_pkt_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int PKT_BITS = 72,
   parameter int CNT_BITS = 16
) (
   input  logic                         clk,
   input  logic                         nreset,
   input  logic [NUM_REQ-1:0]           en,
   input  logic                         pri_mode,
   input  logic [NUM_REQ*PKT_BITS-1:0]  req_data,
   input  logic [NUM_REQ-1:0]           req_vld,
   output logic [NUM_REQ-1:0]           req_rdy,
   output logic [PKT_BITS-1:0]          pkt_data,
   output logic                         pkt_vld,
   input  logic                         pkt_rdy,
   output logic [NUM_REQ-1:0]           grant,
   input  logic                         cnt_clr,
   output logic [NUM_REQ*CNT_BITS-1:0]  cnt
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NUM_REQ);

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   state_t              state_q;
   logic [PKT_BITS-1:0] data_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [IDX_W-1:0]    last_q;
   logic [CNT_BITS-1:0] cnt_q [NUM_REQ];

   logic [NUM_REQ-1:0]  cand;
   logic [NUM_REQ-1:0]  win_oh;
   logic [IDX_W-1:0]    win;
   logic [IDX_W:0]      idx;
   logic [PKT_BITS-1:0] win_data;
   logic                load;
   logic                accept;

   assign cand   = req_vld & en;
   assign load   = (state_q == ST_EMPTY) | pkt_rdy;
   assign accept = load & (|cand);

   // Searching from the far end and overwriting leaves the nearest candidate as winner.
   always_comb begin
      win = '0;
      idx = '0;
      if (pri_mode) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) win = IDX_W'(i);
         end
      end else begin
         for (int k = NUM_REQ; k >= 1; k--) begin
            idx = {1'b0, last_q} + (IDX_W+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (cand[idx[IDX_W-1:0]]) win = idx[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      win_oh   = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == IDX_W'(i)) begin
            win_oh[i] = 1'b1;
            win_data  = req_data[i*PKT_BITS +: PKT_BITS];
         end
      end
   end

   assign req_rdy = accept ? win_oh : '0;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
      end else if (accept) begin
         state_q <= ST_FULL;
         data_q  <= win_data;
         grant_q <= win_oh;
         last_q  <= win;
      end else if (load) begin
         state_q <= ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_clr) begin
               cnt_q[i] <= '0;
            end else if (req_rdy[i] && (cnt_q[i] != {CNT_BITS{1'b1}})) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign cnt[g*CNT_BITS +: CNT_BITS] = cnt_q[g];
   end

   assign pkt_data = data_q;
   assign pkt_vld  = (state_q == ST_FULL);
   assign grant    = grant_q;

endmodule

// File: tb/tb_spinn_pkt_arbiter.sv
// tb/tb_spinn_pkt_arbiter.sv - self-checking bench for spinn_pkt_arbiter against a packet-level model
module tb_spinn_pkt_arbiter;

   localparam int N  = 2;
   localparam int PB = 72;
   localparam int CB = 4;
   localparam logic [PB-1:0] BP_PKT = 72'h0123_4567_89AB_CDEF_01;

   logic              clk;
   logic              nreset;
   logic [N-1:0]      en;
   logic              pri_mode;
   logic [N*PB-1:0]   req_data;
   logic [N-1:0]      req_vld;
   logic [N-1:0]      req_rdy;
   logic [PB-1:0]     pkt_data;
   logic              pkt_vld;
   logic              pkt_rdy;
   logic [N-1:0]      grant;
   logic              cnt_clr;
   logic [N*CB-1:0]   cnt;

   int tests = 0;
   int fails = 0;

   bit            m_full;
   logic [PB-1:0] m_data;
   logic [N-1:0]  m_grant;
   int            m_last;
   int            m_cnt [N];

   spinn_pkt_arbiter #(.NUM_REQ(N), .PKT_BITS(PB), .CNT_BITS(CB)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .en       (en),
      .pri_mode (pri_mode),
      .req_data (req_data),
      .req_vld  (req_vld),
      .req_rdy  (req_rdy),
      .pkt_data (pkt_data),
      .pkt_vld  (pkt_vld),
      .pkt_rdy  (pkt_rdy),
      .grant    (grant),
      .cnt_clr  (cnt_clr),
      .cnt      (cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full  = 1'b0;
      m_data  = '0;
      m_grant = '0;
      m_last  = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) req_data[i*PB +: PB] = {8'($urandom), $urandom, $urandom};
   endtask

   // Winner among enabled, valid requesters; -1 when nobody qualifies.
   function automatic int pick();
      int w = -1;
      if (pri_mode) begin
         for (int i = 0; i < N; i++)
            if (w < 0 && req_vld[i] && en[i]) w = i;
      end else begin
         for (int k = 1; k <= N; k++) begin
            int j = (m_last + k) % N;
            if (w < 0 && req_vld[j] && en[j]) w = j;
         end
      end
      return w;
   endfunction

   // Called just after a rising edge with inputs set; checks at the falling edge, advances the model.
   task automatic cycle();
      int           w;
      bit           ld;
      logic [N-1:0] exp_rdy;
      logic [N*CB-1:0] exp_cnt;
      @(negedge clk);
      ld = !m_full || pkt_rdy;
      w  = pick();
      exp_rdy = (ld && w >= 0) ? N'(1 << w) : '0;
      for (int i = 0; i < N; i++) exp_cnt[i*CB +: CB] = CB'(m_cnt[i]);
      check("req_rdy",  PB'(req_rdy), PB'(exp_rdy));
      check("pkt_vld",  PB'(pkt_vld), PB'(m_full));
      check("pkt_data", pkt_data,     m_data);
      check("grant",    PB'(grant),   PB'(m_grant));
      check("cnt",      PB'(cnt),     PB'(exp_cnt));
      if (ld && w >= 0) begin
         m_full  = 1'b1;
         m_data  = req_data[w*PB +: PB];
         m_grant = N'(1 << w);
         m_last  = w;
      end else if (ld) begin
         m_full = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (cnt_clr) m_cnt[i] = 0;
         else if (exp_rdy[i] && m_cnt[i] < (1 << CB) - 1) m_cnt[i]++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      nreset   = 1'b0;
      en       = '0;
      pri_mode = 1'b0;
      req_data = '0;
      req_vld  = '0;
      pkt_rdy  = 1'b0;
      cnt_clr  = 1'b0;
      model_reset();
      #12;
      check("rst_vld",   PB'(pkt_vld), '0);
      check("rst_data",  pkt_data,     '0);
      check("rst_grant", PB'(grant),   '0);
      check("rst_cnt",   PB'(cnt),     '0);
      @(posedge clk);
      #1;
      nreset = 1'b1;

      // Round-robin with both sources always offering
      en = 2'b11; pri_mode = 1'b0; req_vld = 2'b11; pkt_rdy = 1'b1;
      repeat (8) begin rand_data(); cycle(); end

      // Fixed priority, then requester 0 goes idle
      pri_mode = 1'b1;
      repeat (6) begin rand_data(); cycle(); end
      req_vld = 2'b10;
      repeat (2) begin rand_data(); cycle(); end

      // Backpressure holding a known packet
      req_vld = 2'b01;
      req_data[PB-1:0] = BP_PKT;
      cycle();
      req_vld = 2'b11; pkt_rdy = 1'b0;
      repeat (5) begin
         rand_data();
         cycle();
         check("bp_data", pkt_data,       BP_PKT);
         check("bp_rdy",  PB'(req_rdy),   '0);
      end
      pkt_rdy = 1'b1;
      rand_data();
      cycle();

      // Enable mask, then disable the held source
      pri_mode = 1'b0; en = 2'b10;
      repeat (3) begin rand_data(); cycle(); end
      pkt_rdy = 1'b0; en = 2'b00;
      cycle();
      pkt_rdy = 1'b1;
      cycle();
      cycle();
      check("en_drained", PB'(pkt_vld), '0);

      // Counter clear-with-accept and saturation
      en = 2'b01; req_vld = 2'b01; cnt_clr = 1'b1;
      rand_data();
      cycle();
      check("clr_accept", PB'(cnt[CB-1:0]), '0);
      cnt_clr = 1'b0;
      repeat (20) begin rand_data(); cycle(); end
      check("cnt_sat", PB'(cnt[CB-1:0]), PB'(4'hF));
      cnt_clr = 1'b1;
      cycle();
      check("cnt_clr", PB'(cnt[CB-1:0]), '0);
      cnt_clr = 1'b0;

      // Randomized traffic
      repeat (300) begin
         en       = N'($urandom);
         pri_mode = 1'($urandom);
         req_vld  = N'($urandom);
         pkt_rdy  = ($urandom_range(0, 3) != 0);
         cnt_clr  = ($urandom_range(0, 31) == 0);
         rand_data();
         cycle();
      end
      cnt_clr = 1'b0;

      // Asynchronous reset while full
      en = 2'b11; req_vld = 2'b11; pkt_rdy = 1'b0;
      rand_data();
      cycle();
      check("pre_rst_vld", PB'(pkt_vld), PB'(1'b1));
      nreset = 1'b0;
      #1;
      check("arst_vld",   PB'(pkt_vld), '0);
      check("arst_cnt",   PB'(cnt),     '0);
      check("arst_grant", PB'(grant),   '0);
      check("arst_data",  pkt_data,     '0);
      model_reset();
      @(posedge clk);
      #1;
      nreset = 1'b1;
      pri_mode = 1'b0; en = 2'b11; req_vld = 2'b11; pkt_rdy = 1'b1;
      rand_data();
      cycle();
      check("rst_first_grant", PB'(grant), PB'(2'b01));
      rand_data();
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
